// File: rtl/add_accumulator_pkg.sv
// Shared types for the add_accumulator frame summer: FSM state encoding and beat width.
// The beat is the adder stage's 9-bit {CarryOut,Sum} result.
package add_acc_pkg;

  localparam int BEAT_W = 9;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  function automatic logic [BEAT_W-1:0] make_beat(input logic carry, input logic [7:0] sum);
    return {carry, sum};
  endfunction

endpackage

// File: rtl/add_accumulator_if.sv
// Stream bundle between the adder stage, the accumulator and its downstream consumer.
// The master side drives beats, Clear and OutReady; the slave side is the accumulator.
interface add_accumulator_if #(
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 4
) ();

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic             InValid;
  logic             InReady;
  logic [7:0]       Sum;
  logic             CarryOut;
  logic             Clear;
  logic             OutValid;
  logic             OutReady;
  logic [ACC_W-1:0] AccOut;
  logic [CNT_W-1:0] BeatCount;
  logic             Overflow;

  modport master (
    output InValid, Sum, CarryOut, Clear, OutReady,
    input  InReady, OutValid, AccOut, BeatCount, Overflow
  );

  modport slave (
    input  InValid, Sum, CarryOut, Clear, OutReady,
    output InReady, OutValid, AccOut, BeatCount, Overflow
  );

endinterface

// File: rtl/add_accumulator.sv
// Sums FRAME_LEN adder beats into an ACC_W-bit total and holds it on a valid/ready output.
// Define ADD_ACC_SAT_EN to saturate the total on overflow instead of wrapping.
module add_accumulator
  import add_acc_pkg::*;
#(
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 4
) (
  input logic              clk,
  input logic              rst,
  add_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [BEAT_W-1:0] beat;
  logic [SUM_W-1:0] sum_ext;

  assign beat    = make_beat(bus.CarryOut, bus.Sum);
  // One extra bit so the carry out of the top accumulator bit is visible.
  assign sum_ext = {1'b0, acc_q} + SUM_W'(beat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Clear wins over both an offered beat and a downstream take.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (bus.Clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.InValid) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (sum_ext[ACC_W]) begin
              ovf_d = 1'b1;
            end
`ifdef ADD_ACC_SAT_EN
            acc_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
            acc_d = sum_ext[ACC_W-1:0];
`endif
            if (cnt_q == LAST_BEAT) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.OutReady) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.InReady   = (state_q == ACCUM);
  assign bus.OutValid  = (state_q == HOLD);
  assign bus.AccOut    = acc_q;
  assign bus.BeatCount = cnt_q;
  assign bus.Overflow  = ovf_q;

endmodule

// File: tb/tb_add_accumulator.sv
// Directed scoreboard bench for add_accumulator: default, narrow-overflow and single-beat frames.
// Frame totals are queued when the beats are driven and popped when OutValid appears.
module tb_add_accumulator;
  import add_acc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_accumulator_if #(.ACC_W(16), .FRAME_LEN(4)) bus ();
  add_accumulator_if #(.ACC_W(10), .FRAME_LEN(3)) bus6 ();
  add_accumulator_if #(.ACC_W(16), .FRAME_LEN(1)) bus1 ();

  add_accumulator #(.ACC_W(16), .FRAME_LEN(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  add_accumulator #(.ACC_W(10), .FRAME_LEN(3)) dut6 (.clk(clk), .rst(rst), .bus(bus6));
  add_accumulator #(.ACC_W(16), .FRAME_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    logic [31:0] acc;
    logic        ovf;
  } frame_t;

  frame_t sb[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] accOf(input int sel);
    logic [31:0] r;
    r = '0;
    case (sel)
      0: r = 32'(bus.AccOut);
      1: r = 32'(bus6.AccOut);
      default: r = 32'(bus1.AccOut);
    endcase
    return r;
  endfunction

  function automatic logic ovfOf(input int sel);
    logic r;
    r = 1'b0;
    case (sel)
      0: r = bus.Overflow;
      1: r = bus6.Overflow;
      default: r = bus1.Overflow;
    endcase
    return r;
  endfunction

  function automatic logic validOf(input int sel);
    logic r;
    r = 1'b0;
    case (sel)
      0: r = bus.OutValid;
      1: r = bus6.OutValid;
      default: r = bus1.OutValid;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic valid, input logic carry,
                               input logic [7:0] sum, input logic clear, input logic oready);
    case (sel)
      0: begin
        bus.InValid = valid; bus.CarryOut = carry; bus.Sum = sum;
        bus.Clear = clear; bus.OutReady = oready;
      end
      1: begin
        bus6.InValid = valid; bus6.CarryOut = carry; bus6.Sum = sum;
        bus6.Clear = clear; bus6.OutReady = oready;
      end
      default: begin
        bus1.InValid = valid; bus1.CarryOut = carry; bus1.Sum = sum;
        bus1.Clear = clear; bus1.OutReady = oready;
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic checkFrame(input string tag, input int sel);
    frame_t exp;
    for (int i = 0; i < 20 && !validOf(sel); i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput({tag, " OutValid"}, 32'(validOf(sel)), 32'd1);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL %s scoreboard: observed empty expected entry", tag);
    end
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      checkOutput({tag, " AccOut"}, accOf(sel), exp.acc);
      checkOutput({tag, " Overflow"}, 32'(ovfOf(sel)), 32'(exp.ovf));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [8:0]  beats2 [4];
    logic [31:0] total;
    logic [31:0] exp6;
    logic        pat [7];
    int          accepted;

    rst = 1'b1;
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset AccOut", 32'(bus.AccOut), 32'h0);
    checkOutput("reset BeatCount", 32'(bus.BeatCount), 32'h0);
    checkOutput("reset Overflow", 32'(bus.Overflow), 32'h0);
    checkOutput("reset OutValid", 32'(bus.OutValid), 32'h0);
    checkOutput("reset InReady", 32'(bus.InReady), 32'h1);

    $display("[TB] default frame");
    beats2[0] = 9'h010; beats2[1] = 9'h1FF; beats2[2] = 9'h001; beats2[3] = 9'h100;
    total = '0;
    for (int i = 0; i < 4; i++) total += 32'(beats2[i]);
    sb.push_back('{acc: total, ovf: 1'b0});
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, beats2[i][8], beats2[i][7:0], 1'b0, 1'b0);
      if (i == 0) checkOutput("frame first AccOut", 32'(bus.AccOut), 32'h10);
    end
    checkOutput("frame OutValid after last", 32'(bus.OutValid), 32'h1);
    checkOutput("frame InReady in hold", 32'(bus.InReady), 32'h0);
    checkOutput("frame BeatCount", 32'(bus.BeatCount), 32'h4);
    checkFrame("frame", 0);

    $display("[TB] backpressure");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0);
      checkOutput("stall AccOut", 32'(bus.AccOut), 32'h310);
      checkOutput("stall BeatCount", 32'(bus.BeatCount), 32'h4);
    end
    applyStimulus(0, 1'b1, 1'b0, 8'h05, 1'b0, 1'b1);
    checkOutput("release AccOut", 32'(bus.AccOut), 32'h0);
    checkOutput("release InReady", 32'(bus.InReady), 32'h1);
    checkOutput("release OutValid", 32'(bus.OutValid), 32'h0);
    checkOutput("release BeatCount", 32'(bus.BeatCount), 32'h0);

    $display("[TB] gapped beats");
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    accepted = 0;
    sb.push_back('{acc: 32'd4 * 32'h5, ovf: 1'b0});
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, pat[i], 1'b0, 8'h05, 1'b0, 1'b0);
      if (pat[i]) accepted++;
      checkOutput("gap OutValid", 32'(bus.OutValid), (accepted == 4) ? 32'h1 : 32'h0);
    end
    checkFrame("gap", 0);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    $display("[TB] clear mid-frame");
    applyStimulus(0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("preclear AccOut", 32'(bus.AccOut), 32'h200);
    checkOutput("preclear BeatCount", 32'(bus.BeatCount), 32'h2);
    applyStimulus(0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    checkOutput("clear AccOut", 32'(bus.AccOut), 32'h0);
    checkOutput("clear BeatCount", 32'(bus.BeatCount), 32'h0);
    checkOutput("clear InReady", 32'(bus.InReady), 32'h1);
    sb.push_back('{acc: 32'd1 + 32'd2 + 32'd3 + 32'd4, ovf: 1'b0});
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkFrame("restart", 0);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("clear in hold OutValid", 32'(bus.OutValid), 32'h0);
    checkOutput("clear in hold AccOut", 32'(bus.AccOut), 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] overflow ACC_W=10 FRAME_LEN=3");
    total = 32'd3 * 32'h1FF;
`ifdef ADD_ACC_SAT_EN
    exp6 = (total > 32'h3FF) ? 32'h3FF : total;
`else
    exp6 = total & 32'h3FF;
`endif
    sb.push_back('{acc: exp6, ovf: (total > 32'h3FF)});
    applyStimulus(1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    checkOutput("ovf partial AccOut", 32'(bus6.AccOut), 32'h3FE);
    checkOutput("ovf partial Overflow", 32'(bus6.Overflow), 32'h0);
    applyStimulus(1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkFrame("ovf", 1);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf release Overflow", 32'(bus6.Overflow), 32'h0);
    checkOutput("ovf release AccOut", 32'(bus6.AccOut), 32'h0);

    $display("[TB] single-beat frame");
    sb.push_back('{acc: 32'h123, ovf: 1'b0});
    applyStimulus(2, 1'b1, 1'b1, 8'h23, 1'b0, 1'b0);
    checkOutput("single OutValid", 32'(bus1.OutValid), 32'h1);
    checkOutput("single BeatCount", 32'(bus1.BeatCount), 32'h1);
    checkFrame("single", 2);
    applyStimulus(2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("single release InReady", 32'(bus1.InReady), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
